// File: rtl/alu_issue.sv
// EX-stage issue register for the integer ALU: captures the decoded instruction, detects
// load-use hazards, and forwards MEM/WB results onto the ALU operands and store data.
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic [3:0]      id_aluop,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_reg_we,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic            stall_in,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_reg_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            ex_valid,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_we,
  output logic            ex_is_load,
  output logic [XLEN-1:0] ex_store_data
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            a_sel;
    logic            b_sel;
    logic [3:0]      aluop;
    logic [4:0]      rd_addr;
    logic            reg_we;
    logic            is_load;
  } ex_reg_t;

  localparam ex_reg_t ExBubble = '{
    valid:    1'b0,
    rs1_addr: 5'd0,
    rs2_addr: 5'd0,
    rs1_data: '0,
    rs2_data: '0,
    imm:      '0,
    pc:       '0,
    a_sel:    1'b0,
    b_sel:    1'b0,
    aluop:    ALU_ADD,
    rd_addr:  5'd0,
    reg_we:   1'b0,
    is_load:  1'b0
  };

  ex_reg_t         ex_q, ex_d, id_entry;
  logic            load_use;
  logic            ready_raw;
  logic [XLEN-1:0] rs1_cap, rs2_cap;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // Capture-time bypass covers the register-file write happening in the same cycle as the read.
  always_comb begin
    rs1_cap = id_rs1_data;
    rs2_cap = id_rs2_data;
    if (id_rs1_addr == 5'd0) begin
      rs1_cap = '0;
    end else if (wb_reg_we && (wb_rd_addr == id_rs1_addr)) begin
      rs1_cap = wb_result;
    end
    if (id_rs2_addr == 5'd0) begin
      rs2_cap = '0;
    end else if (wb_reg_we && (wb_rd_addr == id_rs2_addr)) begin
      rs2_cap = wb_result;
    end
  end

  always_comb begin
    id_entry          = ExBubble;
    id_entry.valid    = 1'b1;
    id_entry.rs1_addr = id_rs1_addr;
    id_entry.rs2_addr = id_rs2_addr;
    id_entry.rs1_data = rs1_cap;
    id_entry.rs2_data = rs2_cap;
    id_entry.imm      = id_imm;
    id_entry.pc       = id_pc;
    id_entry.a_sel    = id_a_sel;
    id_entry.b_sel    = id_b_sel;
    id_entry.aluop    = id_aluop;
    id_entry.rd_addr  = id_rd_addr;
    id_entry.reg_we   = id_reg_we;
    id_entry.is_load  = id_is_load;
  end

  // rs2 is always checked because stores read it even when b_sel picks the immediate.
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.is_load && ex_q.reg_we &&
               (ex_q.rd_addr != 5'd0) &&
               ((!id_a_sel && (id_rs1_addr == ex_q.rd_addr)) ||
                (id_rs2_addr == ex_q.rd_addr));
  end

  always_comb begin
    ex_d      = ex_q;
    ready_raw = 1'b0;
    if (stall_in) begin
      ex_d      = ex_q;
      ready_raw = 1'b0;
    end else if (flush) begin
      ex_d      = ExBubble;
      ready_raw = 1'b1;
    end else if (load_use) begin
      ex_d      = ExBubble;
      ready_raw = 1'b0;
    end else if (!id_valid) begin
      ex_d      = ExBubble;
      ready_raw = 1'b1;
    end else begin
      ex_d      = id_entry;
      ready_raw = 1'b1;
    end
  end

  assign id_ready = rst_n & ready_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= ExBubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  // MEM is younger than WB, so it wins when both write the same register.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    rs2_fwd = ex_q.rs2_data;
    if (ex_q.rs1_addr == 5'd0) begin
      rs1_fwd = '0;
    end else if (mem_reg_we && (mem_rd_addr == ex_q.rs1_addr)) begin
      rs1_fwd = mem_result;
    end else if (wb_reg_we && (wb_rd_addr == ex_q.rs1_addr)) begin
      rs1_fwd = wb_result;
    end
    if (ex_q.rs2_addr == 5'd0) begin
      rs2_fwd = '0;
    end else if (mem_reg_we && (mem_rd_addr == ex_q.rs2_addr)) begin
      rs2_fwd = mem_result;
    end else if (wb_reg_we && (wb_rd_addr == ex_q.rs2_addr)) begin
      rs2_fwd = wb_result;
    end
  end

  assign alu_a         = ex_q.a_sel ? ex_q.pc : rs1_fwd;
  assign alu_b         = ex_q.b_sel ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_op        = ex_q.aluop;
  assign ex_valid      = ex_q.valid;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_we     = ex_q.reg_we;
  assign ex_is_load    = ex_q.is_load;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected EX-stage outputs are queued when an instruction is
// offered and compared one clock later.
module tb_alu_issue;

  localparam int unsigned XLEN = 32;
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;

  logic            clk, rst_n;
  logic            id_valid, id_ready;
  logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic            id_a_sel, id_b_sel, id_reg_we, id_is_load;
  logic [3:0]      id_aluop;
  logic            flush, stall_in;
  logic [4:0]      mem_rd_addr, wb_rd_addr;
  logic            mem_reg_we, wb_reg_we;
  logic [XLEN-1:0] mem_result, wb_result;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]      alu_op;
  logic            ex_valid, ex_reg_we, ex_is_load;
  logic [4:0]      ex_rd_addr;

  alu_issue #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_pc         (id_pc),
    .id_a_sel      (id_a_sel),
    .id_b_sel      (id_b_sel),
    .id_aluop      (id_aluop),
    .id_rd_addr    (id_rd_addr),
    .id_reg_we     (id_reg_we),
    .id_is_load    (id_is_load),
    .flush         (flush),
    .stall_in      (stall_in),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_we    (mem_reg_we),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_we     (wb_reg_we),
    .wb_result     (wb_result),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_we     (ex_reg_we),
    .ex_is_load    (ex_is_load),
    .ex_store_data (ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                      input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd);
    exp_t e;
    e.v = v; e.rd = rd; e.we = we; e.ld = ld; e.op = op; e.a = a; e.b = b; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(1'b0, 5'd0, 1'b0, 1'b0, ADD, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic cmp(input string tag);
    exp_t e;
    #1;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(ex_valid), 32'(e.v));
      chk({tag, "_rd"}, 32'(ex_rd_addr), 32'(e.rd));
      chk({tag, "_we"}, 32'(ex_reg_we), 32'(e.we));
      chk({tag, "_ld"}, 32'(ex_is_load), 32'(e.ld));
      chk({tag, "_op"}, 32'(alu_op), 32'(e.op));
      chk({tag, "_a"}, alu_a, e.a);
      chk({tag, "_b"}, alu_b, e.b);
      chk({tag, "_sd"}, ex_store_data, e.sd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_pc = 0; id_a_sel = 0; id_b_sel = 0; id_aluop = ADD; id_rd_addr = 0;
    id_reg_we = 0; id_is_load = 0; flush = 0; stall_in = 0;
    mem_rd_addr = 0; mem_reg_we = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_we = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                        input logic asel, input logic bsel, input logic [3:0] op,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = 1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_pc = pc; id_a_sel = asel; id_b_sel = bsel; id_aluop = op;
    id_rd_addr = rd; id_reg_we = we; id_is_load = ld;
  endtask

  initial begin
    rst_n = 0;
    idle();
    set_id(5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0, SUB, 5'd3, 1'b1, 1'b1);
    #12;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_we", 32'(ex_reg_we), 32'd0);
    chk("rst_ld", 32'(ex_is_load), 32'd0);
    chk("rst_op", 32'(alu_op), 32'(ADD));
    chk("rst_a", alu_a, 32'h0);
    chk("rst_b", alu_b, 32'h0);
    chk("rst_sd", ex_store_data, 32'h0);
    chk("rst_ready", 32'(id_ready), 32'd0);
    @(negedge clk); rst_n = 1; idle();
    push_bubble(); tick(); cmp("idle0");

    // Back-to-back dependency resolved from MEM
    @(negedge clk); idle();
    set_id(5'd2, 5'd3, 32'd7, 32'd9, 32'h0, 32'h100, 1'b0, 1'b0, ADD, 5'd5, 1'b1, 1'b0);
    #1 chk("add_ready", 32'(id_ready), 32'd1);
    push(1'b1, 5'd5, 1'b1, 1'b0, ADD, 32'd7, 32'd9, 32'd9);
    tick(); cmp("add");
    @(negedge clk); idle();
    set_id(5'd5, 5'd1, 32'h0, 32'h3, 32'h0, 32'h104, 1'b0, 1'b0, SUB, 5'd6, 1'b1, 1'b0);
    #1 chk("sub_ready", 32'(id_ready), 32'd1);
    push(1'b1, 5'd6, 1'b1, 1'b0, SUB, 32'h10, 32'h3, 32'h3);
    tick(); mem_rd_addr = 5'd5; mem_reg_we = 1; mem_result = 32'h10; cmp("sub_fwd");

    // Load-use: one bubble then WB forwarding to both operands
    @(negedge clk); idle();
    set_id(5'd2, 5'd0, 32'h200, 32'h0, 32'h0, 32'h108, 1'b0, 1'b1, ADD, 5'd7, 1'b1, 1'b1);
    push(1'b1, 5'd7, 1'b1, 1'b1, ADD, 32'h200, 32'h0, 32'h0);
    tick(); cmp("lw");
    @(negedge clk); idle();
    set_id(5'd7, 5'd7, 32'h0, 32'h0, 32'h0, 32'h10c, 1'b0, 1'b0, ADD, 5'd8, 1'b1, 1'b0);
    #1 chk("lu_ready0", 32'(id_ready), 32'd0);
    push_bubble(); tick(); cmp("lu_bubble");
    @(negedge clk);
    #1 chk("lu_ready1", 32'(id_ready), 32'd1);
    push(1'b1, 5'd8, 1'b1, 1'b0, ADD, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    tick(); wb_rd_addr = 5'd7; wb_reg_we = 1; wb_result = 32'hDEADBEEF; cmp("lu_fwd");

    // Load followed by a PC-relative op naming the load's rd as rs1: no hazard
    @(negedge clk); idle();
    set_id(5'd2, 5'd0, 32'h300, 32'h0, 32'h0, 32'h110, 1'b0, 1'b1, ADD, 5'd7, 1'b1, 1'b1);
    push(1'b1, 5'd7, 1'b1, 1'b1, ADD, 32'h300, 32'h0, 32'h0);
    tick(); cmp("lw2");
    @(negedge clk); idle();
    set_id(5'd7, 5'd0, 32'h5, 32'h0, 32'h20, 32'h114, 1'b1, 1'b1, ADD, 5'd9, 1'b1, 1'b0);
    #1 chk("pc_ready", 32'(id_ready), 32'd1);
    push(1'b1, 5'd9, 1'b1, 1'b0, ADD, 32'h114, 32'h20, 32'h0);
    tick(); cmp("pc_imm");

    // MEM over WB priority; x0 reads zero and is never forwarded
    @(negedge clk); idle();
    set_id(5'd3, 5'd0, 32'h55, 32'h77, 32'h0, 32'h118, 1'b0, 1'b0, ADD, 5'd10, 1'b1, 1'b0);
    push(1'b1, 5'd10, 1'b1, 1'b0, ADD, 32'h1, 32'h0, 32'h0);
    tick();
    mem_rd_addr = 5'd3; mem_reg_we = 1; mem_result = 32'h1;
    wb_rd_addr = 5'd3; wb_reg_we = 1; wb_result = 32'h2;
    cmp("prio");
    @(negedge clk); idle();
    set_id(5'd0, 5'd4, 32'h99, 32'h5, 32'h0, 32'h11c, 1'b0, 1'b0, SUB, 5'd11, 1'b1, 1'b0);
    push(1'b1, 5'd11, 1'b1, 1'b0, SUB, 32'h0, 32'h44, 32'h44);
    tick();
    mem_rd_addr = 5'd0; mem_reg_we = 1; mem_result = 32'hFF;
    wb_rd_addr = 5'd4; wb_reg_we = 1; wb_result = 32'h44;
    cmp("x0");

    // Store: B is the immediate, store data is still forwarded rs2
    @(negedge clk); idle();
    set_id(5'd1, 5'd2, 32'h1000, 32'hAB, 32'h8, 32'h120, 1'b0, 1'b1, ADD, 5'd0, 1'b0, 1'b0);
    push(1'b1, 5'd0, 1'b0, 1'b0, ADD, 32'h1000, 32'h8, 32'hCD);
    tick(); mem_rd_addr = 5'd2; mem_reg_we = 1; mem_result = 32'hCD; cmp("store");

    // Stall with flush holds EX; forwarding still tracks; then flush alone bubbles
    @(negedge clk); idle();
    set_id(5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h124, 1'b0, 1'b0, SUB, 5'd12, 1'b1, 1'b0);
    push(1'b1, 5'd12, 1'b1, 1'b0, SUB, 32'h1, 32'h2, 32'h2);
    tick(); cmp("pre_stall");
    @(negedge clk); idle();
    set_id(5'd5, 5'd6, 32'h50, 32'h60, 32'h0, 32'h128, 1'b0, 1'b0, ADD, 5'd13, 1'b1, 1'b0);
    stall_in = 1; flush = 1;
    #1 chk("stall_ready1", 32'(id_ready), 32'd0);
    push(1'b1, 5'd12, 1'b1, 1'b0, SUB, 32'h1, 32'h2, 32'h2);
    tick(); cmp("stall1");
    @(negedge clk);
    #1 chk("stall_ready2", 32'(id_ready), 32'd0);
    push(1'b1, 5'd12, 1'b1, 1'b0, SUB, 32'h77, 32'h2, 32'h2);
    tick(); mem_rd_addr = 5'd1; mem_reg_we = 1; mem_result = 32'h77; cmp("stall2_fwd");
    @(negedge clk); stall_in = 0;
    #1 chk("flush_ready", 32'(id_ready), 32'd1);
    push_bubble(); tick(); cmp("flush");

    // Capture-time bypass from the WB write port
    @(negedge clk); idle();
    set_id(5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 32'h12c, 1'b0, 1'b0, ADD, 5'd14, 1'b1, 1'b0);
    wb_rd_addr = 5'd4; wb_reg_we = 1; wb_result = 32'h1234;
    push(1'b1, 5'd14, 1'b1, 1'b0, ADD, 32'h1234, 32'h0, 32'h0);
    tick(); wb_rd_addr = 5'd0; wb_reg_we = 0; wb_result = 32'h0; cmp("cap_byp");

    @(negedge clk); idle();
    push_bubble(); tick(); cmp("no_valid");

    // Asynchronous reset between edges
    @(negedge clk); idle();
    set_id(5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 32'h130, 1'b0, 1'b0, SUB, 5'd15, 1'b1, 1'b0);
    push(1'b1, 5'd15, 1'b1, 1'b0, SUB, 32'h3, 32'h4, 32'h4);
    tick(); cmp("pre_rst");
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_op", 32'(alu_op), 32'(ADD));
    chk("arst_a", alu_a, 32'h0);
    chk("arst_we", 32'(ex_reg_we), 32'd0);
    chk("arst_ready", 32'(id_ready), 32'd0);
    @(negedge clk); rst_n = 1; idle();
    push_bubble(); tick(); cmp("post_rst");

    // Reset during a pending load-use leaves no hazard behind
    @(negedge clk); idle();
    set_id(5'd2, 5'd0, 32'h400, 32'h0, 32'h0, 32'h134, 1'b0, 1'b1, ADD, 5'd7, 1'b1, 1'b1);
    push(1'b1, 5'd7, 1'b1, 1'b1, ADD, 32'h400, 32'h0, 32'h0);
    tick(); cmp("lw3");
    @(negedge clk); idle();
    set_id(5'd7, 5'd7, 32'h11, 32'h22, 32'h0, 32'h138, 1'b0, 1'b0, ADD, 5'd8, 1'b1, 1'b0);
    #1 chk("lu3_ready", 32'(id_ready), 32'd0);
    #2 rst_n = 0;
    #1 chk("arst2_ld", 32'(ex_is_load), 32'd0);
    @(negedge clk); rst_n = 1;
    #1 chk("rst2_ready", 32'(id_ready), 32'd1);
    push(1'b1, 5'd8, 1'b1, 1'b0, ADD, 32'h11, 32'h22, 32'h22);
    tick(); cmp("after_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
